queue_drain: RTL and testbench
==============================

Name: queue_drain

Overview:
- Consumer-side engine for the spy capture FIFO. It watches the FIFO occupancy and pops entries through the FIFO read port (valueOut/consumed/empty/counter).
- Pops in bursts and forwards each entry on a valid/ready output stream, with last marking the final beat of each burst.
- A burst starts when occupancy reaches a programmable threshold, or while flush is held.
- Sits between the capture FIFO and the exfiltration/AXI writer path. Hides the FIFO's registered BRAM read latency from the downstream sink.

Parameters:
- DATA_SIZE, 32, width of a FIFO entry and of m_data.
- QUEUE_LENGTH, 4, depth of the attached FIFO; sets the counter width to $clog2(QUEUE_LENGTH)+1.
- REGISTER_SIZE, 32, width of the threshold and statistics registers.
- READ_LATENCY, 2, cycles from a consumed pulse until the FIFO's valueOut shows the next entry (1 for the head update, 1 for the BRAM output register).
- MAX_BURST, 16, upper cap on beats per burst.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset.
- higher_threshold  in  REGISTER_SIZE  occupancy that triggers a burst; a value of 0 is treated as 1.
- flush  in  1  level signal; while high, drain whenever the FIFO is not empty, ignoring the threshold.
- q_valueOut  in  DATA_SIZE  FIFO head data.
- q_empty  in  1  FIFO empty flag.
- q_counter  in  $clog2(QUEUE_LENGTH)+1  FIFO occupancy.
- q_consumed  out  1  one-cycle pop strobe to the FIFO.
- m_valid  out  1  output beat valid.
- m_ready  in  1  sink ready.
- m_data  out  DATA_SIZE  output beat data.
- m_last  out  1  final beat of the current burst.
- busy  out  1  high in any state other than IDLE.
- beats_sent  out  REGISTER_SIZE  running count of accepted beats; wraps modulo 2^REGISTER_SIZE.
- bursts_done  out  REGISTER_SIZE  running count of completed bursts; wraps modulo 2^REGISTER_SIZE.

Behaviour:
- Reset (reset=0, asynchronous, any state): state=IDLE.
  - q_consumed, m_valid, m_last, busy = 0.
  - m_data, beats_sent, bursts_done, remaining, settle = 0.
  - A burst in flight is abandoned; no further pop is issued.
- Trigger: thr_eff = max(higher_threshold, 1). q_counter is zero-extended to REGISTER_SIZE before comparison.
- State IDLE:
  - Leave IDLE when !q_empty && (flush || q_counter >= thr_eff).
  - On leaving: remaining <= min(q_counter, MAX_BURST); settle <= 0; go to SETTLE.
  - The first settle passes immediately, because the FIFO head data is already stable while idle.
  - Entries written during a burst do not extend it; they are picked up by the next trigger.
- State SETTLE:
  - If settle == 0: m_data <= q_valueOut; m_valid <= 1; m_last <= (remaining == 1); go to SEND.
  - Otherwise: settle decrements by 1 and the state holds.
- State SEND:
  - m_valid, m_data and m_last stay stable until m_ready is sampled high.
  - On a handshake (m_valid && m_ready):
    - q_consumed = 1 for exactly that cycle (combinational from the handshake in SEND).
    - m_valid <= 0; beats_sent += 1; remaining -= 1.
    - If remaining was 1: bursts_done += 1; m_last <= 0; go to IDLE.
    - Otherwise: settle <= READ_LATENCY - 1; go to SETTLE.
- Throughput: at most one beat per READ_LATENCY+1 cycles. Pop-to-next-valid latency is READ_LATENCY cycles.
- Pop safety:
  - q_consumed is never asserted while q_empty=1.
  - If q_empty is seen high in SETTLE (FIFO reset externally), the burst aborts: go to IDLE, m_valid=0, bursts_done unchanged.
- Flush dropping low mid-burst does not shorten the burst.
- Threshold changes take effect only in IDLE.
- q_counter = QUEUE_LENGTH (FIFO full) is a valid trigger. MAX_BURST < q_counter splits the drain into successive bursts.

Test Plan:
- Threshold 3, write 2 entries (0xA1, 0xA2), m_ready=1 -> no m_valid and busy=0 for 20 cycles. Write 0xA3 -> beats A1, A2, A3 in order; m_last only on A3; bursts_done=1; beats_sent=3.
- Threshold 8, 2 entries, then flush=1 for one cycle -> burst of 2 beats, last on beat 2; FIFO empty afterwards.
- Backpressure: 3-entry burst with m_ready low for 5 cycles on beat 2 -> m_data/m_last held constant; exactly one q_consumed per beat; 3 pops total.
- Pop spacing with m_ready=1 and READ_LATENCY=2 -> m_valid rises every 3 cycles; each beat's m_data matches the FIFO entry in write order.
- QUEUE_LENGTH=4, MAX_BURST=2, FIFO full with 0x10..0x13, threshold 4 -> first burst 0x10, 0x11 (last), then IDLE. The second burst needs flush=1 or a refill to reach threshold; with flush=1 it emits 0x12, 0x13 (last).
- Drop reset for one cycle in SEND mid-burst -> all outputs 0 immediately and counters cleared. After release with the FIFO also reset, no pops occur.

Source files
------------

// File: rtl/queue_drain_if.sv
// FIFO read port plus the valid/ready output stream of the drain engine.
// The master side is the drain engine; the slave side is the FIFO and the downstream sink.
interface queue_drain_if #(
    parameter int unsigned DATA_SIZE    = 32,
    parameter int unsigned QUEUE_LENGTH = 4
);
    localparam int unsigned CNT_W = $clog2(QUEUE_LENGTH) + 1;

    logic [DATA_SIZE-1:0] q_valueOut;
    logic                 q_empty;
    logic [CNT_W-1:0]     q_counter;
    logic                 q_consumed;

    logic                 m_valid;
    logic                 m_ready;
    logic [DATA_SIZE-1:0] m_data;
    logic                 m_last;

    modport master (
        input  q_valueOut,
        input  q_empty,
        input  q_counter,
        output q_consumed,
        output m_valid,
        input  m_ready,
        output m_data,
        output m_last
    );

    modport slave (
        output q_valueOut,
        output q_empty,
        output q_counter,
        input  q_consumed,
        input  m_valid,
        output m_ready,
        input  m_data,
        input  m_last
    );
endinterface

// File: rtl/queue_drain.sv
// Burst drain engine for the capture FIFO: pops entries once occupancy reaches a threshold
// (or while flush is held) and forwards them on a valid/ready stream, hiding BRAM read latency.
module queue_drain #(
    parameter int unsigned DATA_SIZE     = 32,
    parameter int unsigned QUEUE_LENGTH  = 4,
    parameter int unsigned REGISTER_SIZE = 32,
    parameter int unsigned READ_LATENCY  = 2,
    parameter int unsigned MAX_BURST     = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [REGISTER_SIZE-1:0] higher_threshold,
    input  logic                     flush,
    queue_drain_if.master            bus,
    output logic                     busy,
    output logic [REGISTER_SIZE-1:0] beats_sent,
    output logic [REGISTER_SIZE-1:0] bursts_done
);
    localparam int unsigned REM_MAX = (MAX_BURST > QUEUE_LENGTH) ? MAX_BURST : QUEUE_LENGTH;
    localparam int unsigned REM_W   = $clog2(REM_MAX) + 1;
    localparam int unsigned SET_W   = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    localparam logic [REM_W-1:0] MaxBurstRem  = REM_W'(MAX_BURST);
    localparam logic [SET_W-1:0] SettleReload = SET_W'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StSend
    } state_e;

    state_e                   state_q, state_d;
    logic [REM_W-1:0]         remaining_q, remaining_d;
    logic [SET_W-1:0]         settle_q, settle_d;
    logic                     m_valid_q, m_valid_d;
    logic                     m_last_q, m_last_d;
    logic [DATA_SIZE-1:0]     m_data_q, m_data_d;
    logic [REGISTER_SIZE-1:0] beats_q, beats_d;
    logic [REGISTER_SIZE-1:0] bursts_q, bursts_d;

    logic [REGISTER_SIZE-1:0] thr_eff;
    logic [REGISTER_SIZE-1:0] occupancy;
    logic [REM_W-1:0]         count_rem;
    logic [REM_W-1:0]         burst_len;
    logic                     trigger;
    logic                     handshake;

    always_comb begin
        thr_eff   = (higher_threshold == '0) ? REGISTER_SIZE'(1) : higher_threshold;
        occupancy = REGISTER_SIZE'(bus.q_counter);
        count_rem = REM_W'(bus.q_counter);
        burst_len = (count_rem >= MaxBurstRem) ? MaxBurstRem : count_rem;
        trigger   = !bus.q_empty && (flush || (occupancy >= thr_eff));
        handshake = (state_q == StSend) && m_valid_q && bus.m_ready;
    end

    // Gated on !q_empty so an externally reset FIFO can never see a pop.
    assign bus.q_consumed = handshake && !bus.q_empty;
    assign bus.m_valid    = m_valid_q;
    assign bus.m_data     = m_data_q;
    assign bus.m_last     = m_last_q;
    assign busy           = (state_q != StIdle);
    assign beats_sent     = beats_q;
    assign bursts_done    = bursts_q;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        settle_d    = settle_q;
        m_valid_d   = m_valid_q;
        m_last_d    = m_last_q;
        m_data_d    = m_data_q;
        beats_d     = beats_q;
        bursts_d    = bursts_q;

        unique case (state_q)
            StIdle: begin
                // Head data is already stable while idle, so the first settle is free.
                if (trigger) begin
                    remaining_d = burst_len;
                    settle_d    = '0;
                    state_d     = StSettle;
                end
            end
            StSettle: begin
                if (bus.q_empty) begin
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                    state_d   = StIdle;
                end else if (settle_q == '0) begin
                    m_data_d  = bus.q_valueOut;
                    m_valid_d = 1'b1;
                    m_last_d  = (remaining_q == REM_W'(1));
                    state_d   = StSend;
                end else begin
                    settle_d = settle_q - SET_W'(1);
                end
            end
            StSend: begin
                if (handshake) begin
                    m_valid_d   = 1'b0;
                    beats_d     = beats_q + REGISTER_SIZE'(1);
                    remaining_d = remaining_q - REM_W'(1);
                    if (remaining_q == REM_W'(1)) begin
                        bursts_d = bursts_q + REGISTER_SIZE'(1);
                        m_last_d = 1'b0;
                        state_d  = StIdle;
                    end else begin
                        settle_d = SettleReload;
                        state_d  = StSettle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            settle_q    <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            m_data_q    <= '0;
            beats_q     <= '0;
            bursts_q    <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            settle_q    <= settle_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            m_data_q    <= m_data_d;
            beats_q     <= beats_d;
            bursts_q    <= bursts_d;
        end
    end
endmodule

// File: tb/tb_queue_drain.sv
// Directed bench for queue_drain: two instances (MAX_BURST 16 and 2) each fed by a small
// FIFO model with a two-cycle registered read path.
module tb_queue_drain;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    queue_drain_if #(.DATA_SIZE(32), .QUEUE_LENGTH(4)) q0 ();
    queue_drain_if #(.DATA_SIZE(32), .QUEUE_LENGTH(4)) q1 ();

    logic [31:0] thr0 = 32'd3, thr1 = 32'd4;
    logic        flush0 = 1'b0, flush1 = 1'b0;
    logic        rdy0 = 1'b1, rdy1 = 1'b1;
    logic        busy0, busy1;
    logic [31:0] bs0, bd0, bs1, bd1;

    queue_drain #(.MAX_BURST(16)) u_dut0 (
        .clock(clock), .reset(reset), .higher_threshold(thr0), .flush(flush0), .bus(q0),
        .busy(busy0), .beats_sent(bs0), .bursts_done(bd0)
    );
    queue_drain #(.MAX_BURST(2)) u_dut1 (
        .clock(clock), .reset(reset), .higher_threshold(thr1), .flush(flush1), .bus(q1),
        .busy(busy1), .beats_sent(bs1), .bursts_done(bd1)
    );

    // FIFO models: pop moves the head at one edge, the output register shows it at the next.
    logic [31:0] fmem [2][4];
    logic [1:0]  rp [2];
    logic [1:0]  wp [2];
    logic [2:0]  fcnt [2];
    logic [31:0] fout [2];
    logic        wr_en [2];
    logic [31:0] wr_data [2];
    logic        fclr [2];
    logic        cons [2];

    assign cons[0] = q0.q_consumed;
    assign cons[1] = q1.q_consumed;
    assign q0.q_valueOut = fout[0];
    assign q1.q_valueOut = fout[1];
    assign q0.q_empty = (fcnt[0] == 3'd0);
    assign q1.q_empty = (fcnt[1] == 3'd0);
    assign q0.q_counter = fcnt[0];
    assign q1.q_counter = fcnt[1];
    assign q0.m_ready = rdy0;
    assign q1.m_ready = rdy1;

    always @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (fclr[i]) begin
                rp[i] <= 2'd0; wp[i] <= 2'd0; fcnt[i] <= 3'd0; fout[i] <= 32'd0;
            end else begin
                if (wr_en[i] && fcnt[i] != 3'd4) begin
                    fmem[i][wp[i]] <= wr_data[i];
                    wp[i] <= wp[i] + 2'd1;
                end
                if (cons[i] && fcnt[i] != 3'd0) rp[i] <= rp[i] + 2'd1;
                fcnt[i] <= fcnt[i] + ((wr_en[i] && fcnt[i] != 3'd4) ? 3'd1 : 3'd0)
                                   - ((cons[i] && fcnt[i] != 3'd0) ? 3'd1 : 3'd0);
                fout[i] <= fmem[i][rp[i]];
            end
        end
    end

    // Stream monitor
    int          cyc = 0;
    int          pops [2];
    int          empty_pops = 0;
    logic        mv_prev0 = 1'b0;
    logic [31:0] bdat0 [$];
    logic [31:0] bdat1 [$];
    logic        blast0 [$];
    logic        blast1 [$];
    int          rise0 [$];

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (q0.m_valid && rdy0) begin bdat0.push_back(q0.m_data); blast0.push_back(q0.m_last); end
        if (q1.m_valid && rdy1) begin bdat1.push_back(q1.m_data); blast1.push_back(q1.m_last); end
        if (q0.q_consumed) pops[0] <= pops[0] + 1;
        if (q1.q_consumed) pops[1] <= pops[1] + 1;
        if ((q0.q_consumed && q0.q_empty) || (q1.q_consumed && q1.q_empty))
            empty_pops <= empty_pops + 1;
        if (q0.m_valid && !mv_prev0) rise0.push_back(cyc);
        mv_prev0 <= q0.m_valid;
    end

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [63:0] dat(input int i, input int j);
        if (i == 0) return (j < bdat0.size()) ? {32'd0, bdat0[j]} : 64'hBAD0_0000_DEAD_BEEF;
        return (j < bdat1.size()) ? {32'd0, bdat1[j]} : 64'hBAD0_0000_DEAD_BEEF;
    endfunction

    function automatic logic [63:0] lst(input int i, input int j);
        if (i == 0) return (j < blast0.size()) ? {63'd0, blast0[j]} : 64'hBAD;
        return (j < blast1.size()) ? {63'd0, blast1[j]} : 64'hBAD;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic push(input int i, input logic [31:0] d);
        @(negedge clock);
        wr_en[i] = 1'b1;
        wr_data[i] = d;
        @(negedge clock);
        wr_en[i] = 1'b0;
    endtask

    task automatic pulse_flush(input int i);
        @(negedge clock);
        if (i == 0) flush0 = 1'b1; else flush1 = 1'b1;
        @(negedge clock);
        flush0 = 1'b0;
        flush1 = 1'b0;
    endtask

    task automatic clear_caps();
        bdat0.delete(); blast0.delete(); bdat1.delete(); blast1.delete(); rise0.delete();
    endtask

    task automatic wait_beats0(input int n, input int budget, input string name);
        int k = 0;
        while (bdat0.size() < n && k < budget) begin @(negedge clock); k++; end
        check(name, 64'(bdat0.size() >= n), 64'd1);
    endtask

    typedef struct {
        logic [31:0] thr;
        int          n;
        bit          fl;
        int          exp_beats;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int          act;
        logic [31:0] bd_before, held;
        int          pop_before;

        vecs[0] = '{thr: 32'd3, n: 2, fl: 1'b0, exp_beats: 0};  // below threshold
        vecs[1] = '{thr: 32'd0, n: 1, fl: 1'b0, exp_beats: 1};  // zero acts as one
        vecs[2] = '{thr: 32'd8, n: 2, fl: 1'b1, exp_beats: 2};  // flush overrides threshold
        vecs[3] = '{thr: 32'd4, n: 4, fl: 1'b0, exp_beats: 4};  // full FIFO triggers
        vecs[4] = '{thr: 32'd2, n: 3, fl: 1'b0, exp_beats: 2};  // late write not added
        vecs[5] = '{thr: 32'd5, n: 4, fl: 1'b0, exp_beats: 0};  // unreachable threshold

        for (int i = 0; i < 2; i++) begin
            fclr[i] = 1'b1; wr_en[i] = 1'b0; wr_data[i] = 32'd0; pops[i] = 0;
        end
        tick(3);
        reset = 1'b1;
        fclr[0] = 1'b0;
        fclr[1] = 1'b0;
        #1;
        check("reset busy", 64'(busy0), 64'd0);
        check("reset m_valid", 64'(q0.m_valid), 64'd0);
        check("reset m_last", 64'(q0.m_last), 64'd0);
        check("reset m_data", 64'(q0.m_data), 64'd0);
        check("reset consumed", 64'(q0.q_consumed), 64'd0);
        check("reset beats_sent", 64'(bs0), 64'd0);
        check("reset bursts_done", 64'(bd0), 64'd0);

        // Below threshold stays idle, third entry triggers a 3-beat burst
        thr0 = 32'd3; rdy0 = 1'b1; clear_caps();
        push(0, 32'hA1); push(0, 32'hA2);
        act = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (busy0 || q0.m_valid) act++;
        end
        check("idle below threshold", 64'(act), 64'd0);
        push(0, 32'hA3);
        wait_beats0(3, 40, "A burst arrives");
        tick(5);
        for (int j = 0; j < 3; j++) begin
            check("A data", dat(0, j), 64'(32'hA1 + j));
            check("A last", lst(0, j), 64'(j == 2));
        end
        check("A beats_sent", 64'(bs0), 64'd3);
        check("A bursts_done", 64'(bd0), 64'd1);
        check("A rise count", 64'(rise0.size()), 64'd3);
        if (rise0.size() == 3) begin
            check("A spacing 1", 64'(rise0[1] - rise0[0]), 64'd3);
            check("A spacing 2", 64'(rise0[2] - rise0[1]), 64'd3);
        end

        // Table of trigger conditions
        for (int v = 0; v < 6; v++) begin
            thr0 = vecs[v].thr;
            clear_caps();
            bd_before = bd0;
            for (int k = 0; k < vecs[v].n; k++) push(0, 32'hF000_0000 + 32'(v << 8) + 32'(k));
            tick(20);
            if (vecs[v].fl) begin pulse_flush(0); tick(20); end
            check($sformatf("vec%0d beats", v), 64'(bdat0.size()), 64'(vecs[v].exp_beats));
            for (int j = 0; j < vecs[v].exp_beats; j++) begin
                check($sformatf("vec%0d data", v), dat(0, j),
                      64'(32'hF000_0000 + 32'(v << 8) + 32'(j)));
                check($sformatf("vec%0d last", v), lst(0, j), 64'(j == vecs[v].exp_beats - 1));
            end
            check($sformatf("vec%0d bursts", v), 64'(bd0 - bd_before),
                  64'(vecs[v].exp_beats > 0));
            check($sformatf("vec%0d idle", v), 64'(busy0), 64'd0);
            pulse_flush(0);
            tick(20);
            check($sformatf("vec%0d drained", v), 64'(q0.q_empty), 64'd1);
        end

        // Backpressure on beat 2
        thr0 = 32'd3; clear_caps(); pop_before = pops[0];
        push(0, 32'hB1); push(0, 32'hB2); push(0, 32'hB3);
        wait_beats0(1, 30, "B first beat");
        rdy0 = 1'b0;
        act = 0;
        while (!q0.m_valid && act < 20) begin @(negedge clock); act++; end
        check("B beat2 valid", 64'(q0.m_valid), 64'd1);
        held = q0.m_data;
        check("B beat2 data", 64'(held), 64'h0B2);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check("B held data", 64'(q0.m_data), 64'h0B2);
            check("B held last", 64'(q0.m_last), 64'd0);
            check("B held valid", 64'(q0.m_valid), 64'd1);
        end
        check("B pops while stalled", 64'(pops[0] - pop_before), 64'd1);
        rdy0 = 1'b1;
        wait_beats0(3, 30, "B burst completes");
        tick(5);
        for (int j = 0; j < 3; j++) begin
            check("B data", dat(0, j), 64'(32'hB1 + j));
            check("B last", lst(0, j), 64'(j == 2));
        end
        check("B total pops", 64'(pops[0] - pop_before), 64'd3);

        // MAX_BURST=2 splits a full FIFO into two bursts
        thr1 = 32'd4; rdy1 = 1'b1;
        push(1, 32'h10); push(1, 32'h11); push(1, 32'h12); push(1, 32'h13);
        tick(30);
        check("C first burst beats", 64'(bdat1.size()), 64'd2);
        check("C data0", dat(1, 0), 64'h10);
        check("C data1", dat(1, 1), 64'h11);
        check("C last0", lst(1, 0), 64'd0);
        check("C last1", lst(1, 1), 64'd1);
        check("C idle between", 64'(busy1), 64'd0);
        check("C left in FIFO", 64'(q1.q_counter), 64'd2);
        pulse_flush(1);
        tick(20);
        check("C second burst beats", 64'(bdat1.size()), 64'd4);
        check("C data2", dat(1, 2), 64'h12);
        check("C data3", dat(1, 3), 64'h13);
        check("C last2", lst(1, 2), 64'd0);
        check("C last3", lst(1, 3), 64'd1);
        check("C bursts_done", 64'(bd1), 64'd2);

        // Asynchronous reset in SEND mid-burst
        thr0 = 32'd3; clear_caps();
        push(0, 32'hD1); push(0, 32'hD2); push(0, 32'hD3);
        act = 0;
        while (!q0.m_valid && act < 30) begin @(negedge clock); act++; end
        check("D in SEND", 64'(q0.m_valid), 64'd1);
        reset = 1'b0;
        fclr[0] = 1'b1;
        #1;
        check("D rst m_valid", 64'(q0.m_valid), 64'd0);
        check("D rst m_data", 64'(q0.m_data), 64'd0);
        check("D rst m_last", 64'(q0.m_last), 64'd0);
        check("D rst busy", 64'(busy0), 64'd0);
        check("D rst consumed", 64'(q0.q_consumed), 64'd0);
        check("D rst beats_sent", 64'(bs0), 64'd0);
        check("D rst bursts_done", 64'(bd0), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        fclr[0] = 1'b0;
        pop_before = pops[0];
        tick(20);
        check("D no pops after", 64'(pops[0] - pop_before), 64'd0);
        check("D idle after", 64'(busy0), 64'd0);
        check("D beats stay 0", 64'(bs0), 64'd0);

        check("no pop while empty", 64'(empty_pops), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
